// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - PWM period/high-time measurement with normalised duty code
module pwm_duty_decoder #(
    parameter int DC_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 PWM_IN,
    output logic [DC_WIDTH-1:0]  DUTY_OUT,
    output logic [CNT_WIDTH-1:0] HIGH_CNT,
    output logic [CNT_WIDTH-1:0] PERIOD_CNT,
    output logic                 VALID,
    output logic                 TIMEOUT,
    output logic                 OVERRUN
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam int                   STEP_W    = $clog2(DC_WIDTH + 1);
    localparam logic [STEP_W-1:0]    STEP_LOAD = STEP_W'(DC_WIDTH);
    localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(1);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t               state;
    logic                 s1;
    logic                 s2;
    logic                 s3;
    logic                 rise;
    logic [CNT_WIDTH-1:0] per_cnt;
    logic [CNT_WIDTH-1:0] hi_cnt;

    // Divider state: remainder stays below the divisor, so CNT_WIDTH bits suffice
    logic                 div_busy;
    logic                 div_sat;
    logic [CNT_WIDTH-1:0] div_rem;
    logic [CNT_WIDTH-1:0] div_den;
    logic [DC_WIDTH-1:0]  div_quo;
    logic [STEP_W-1:0]    div_step;

    logic [CNT_WIDTH:0]   rem_shift;
    logic                 rem_ge;
    logic [CNT_WIDTH-1:0] rem_next;
    logic [DC_WIDTH-1:0]  quo_next;

    assign rise = s2 & ~s3;

    // Two-flop synchroniser plus one delay stage for edge detection
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= PWM_IN;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // One restoring step: quotient bits are produced MSB first, bit index = div_step-1
    always_comb begin
        rem_shift = {div_rem, 1'b0};
        rem_ge    = (rem_shift >= {1'b0, div_den});
        rem_next  = rem_ge ? (rem_shift[CNT_WIDTH-1:0] - div_den) : rem_shift[CNT_WIDTH-1:0];
        quo_next  = div_quo;
        for (int i = 0; i < DC_WIDTH; i++) begin
            if (STEP_W'(i) == (div_step - STEP_LAST)) begin
                quo_next[i] = rem_ge;
            end
        end
    end

    // Measurement FSM, capture registers, divider sequencing and timeout handling
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            div_busy   <= 1'b0;
            div_sat    <= 1'b0;
            div_rem    <= '0;
            div_den    <= '0;
            div_quo    <= '0;
            div_step   <= '0;
            DUTY_OUT   <= '0;
            HIGH_CNT   <= '0;
            PERIOD_CNT <= '0;
            VALID      <= 1'b0;
            TIMEOUT    <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            VALID   <= 1'b0;
            OVERRUN <= 1'b0;

            if (div_busy) begin
                div_rem  <= rem_next;
                div_quo  <= quo_next;
                div_step <= div_step - STEP_LAST;
                if (div_step == STEP_LAST) begin
                    div_busy <= 1'b0;
                    DUTY_OUT <= div_sat ? {DC_WIDTH{1'b1}} : quo_next;
                    VALID    <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        per_cnt <= CNT_ONE;
                        hi_cnt  <= CNT_ONE;
                        state   <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        per_cnt <= CNT_ONE;
                        hi_cnt  <= CNT_ONE;
                        if (!div_busy) begin
                            PERIOD_CNT <= per_cnt;
                            HIGH_CNT   <= hi_cnt;
                            TIMEOUT    <= 1'b0;
                            div_busy   <= 1'b1;
                            div_step   <= STEP_LOAD;
                            div_quo    <= '0;
                            div_den    <= per_cnt;
                            div_sat    <= (hi_cnt >= per_cnt);
                            div_rem    <= (hi_cnt >= per_cnt) ? '0 : hi_cnt;
                        end else begin
                            OVERRUN <= 1'b1;
                        end
                    end else if (per_cnt == CNT_MAX) begin
                        // Line stuck: report the held level as 0% or 100% and drop any divide
                        TIMEOUT    <= 1'b1;
                        HIGH_CNT   <= '0;
                        PERIOD_CNT <= '0;
                        DUTY_OUT   <= s2 ? {DC_WIDTH{1'b1}} : '0;
                        VALID      <= 1'b1;
                        div_busy   <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        per_cnt <= per_cnt + CNT_ONE;
                        hi_cnt  <= hi_cnt + CNT_WIDTH'(s2);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb/tb_pwm_duty_decoder.sv - scoreboard bench for pwm_duty_decoder
module tb_pwm_duty_decoder;

    localparam int DCW  = 8;
    localparam int CNTW = 10;
    localparam int TO   = (1 << CNTW) - 1;

    logic            CLK;
    logic            RESET;
    logic            PWM_IN;
    logic [DCW-1:0]  DUTY_OUT;
    logic [CNTW-1:0] HIGH_CNT;
    logic [CNTW-1:0] PERIOD_CNT;
    logic            VALID;
    logic            TIMEOUT;
    logic            OVERRUN;

    pwm_duty_decoder #(.DC_WIDTH(DCW), .CNT_WIDTH(CNTW)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .PWM_IN     (PWM_IN),
        .DUTY_OUT   (DUTY_OUT),
        .HIGH_CNT   (HIGH_CNT),
        .PERIOD_CNT (PERIOD_CNT),
        .VALID      (VALID),
        .TIMEOUT    (TIMEOUT),
        .OVERRUN    (OVERRUN)
    );

    typedef struct {
        int per;
        int hi;
        int duty;
        int to;
        int cyc;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;

    int n_checks  = 0;
    int n_err     = 0;
    int cyc       = 0;
    int armed     = 0;
    int last_rise = 0;
    int last_cap  = -1000;
    int last_hi   = 0;
    int exp_ovr   = 0;
    int ovr_seen  = 0;

    initial CLK = 1'b0;
    always #50 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // A rise is driven now: capture of the previous period unless divider still busy
    task automatic note_rise();
        exp_t e;
        if (armed != 0) begin
            if (cyc - last_cap >= DCW + 1) begin
                e.per  = cyc - last_rise;
                e.hi   = last_hi;
                e.duty = (e.hi << DCW) / e.per;
                if (e.duty > (1 << DCW) - 1) e.duty = (1 << DCW) - 1;
                e.to   = 0;
                e.cyc  = cyc + DCW + 3;
                expq.push_back(e);
                last_cap = cyc;
            end else begin
                exp_ovr++;
            end
        end
        armed     = 1;
        last_rise = cyc;
    endtask

    task automatic pulse(input int hi, input int per);
        note_rise();
        PWM_IN = 1'b1;
        repeat (hi) @(negedge CLK);
        PWM_IN = 1'b0;
        repeat (per - hi) @(negedge CLK);
        last_hi = hi;
    endtask

    task automatic pulses(input int hi, input int per, input int n);
        for (int i = 0; i < n; i++) pulse(hi, per);
    endtask

    // Hold the current level until the timeout fires, then return low
    task automatic timeout_wait();
        exp_t e;
        e.per  = 0;
        e.hi   = 0;
        e.duty = PWM_IN ? (1 << DCW) - 1 : 0;
        e.to   = 1;
        e.cyc  = last_rise + TO + 3;
        expq.push_back(e);
        while (cyc < last_rise + TO + 8) @(negedge CLK);
        armed  = 0;
        PWM_IN = 1'b0;
        repeat (5) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (RESET === 1'b1) begin
            if (OVERRUN === 1'b1) ovr_seen++;
            if (VALID === 1'b1) begin
                if (expq.size() == 0) begin
                    check("valid_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = expq.pop_front();
                    check("valid_cyc", cyc, mon_e.cyc);
                    check("period_cnt", 32'(PERIOD_CNT), mon_e.per);
                    check("high_cnt", 32'(HIGH_CNT), mon_e.hi);
                    check("duty_out", 32'(DUTY_OUT), mon_e.duty);
                    check("timeout", 32'(TIMEOUT), mon_e.to);
                end
            end
        end
    end

    initial begin
        int dcs[8];
        dcs = '{1, 2, 64, 127, 128, 200, 254, 255};
        PWM_IN = 1'b0;
        RESET  = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_duty", 32'(DUTY_OUT), 0);
        check("rst_high", 32'(HIGH_CNT), 0);
        check("rst_period", 32'(PERIOD_CNT), 0);
        check("rst_valid", 32'(VALID), 0);
        check("rst_timeout", 32'(TIMEOUT), 0);
        check("rst_overrun", 32'(OVERRUN), 0);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

        // Period 100, high 25
        pulses(25, 100, 4);

        // Duty sweep at period 256: duty code equals high time
        for (int i = 0; i < 8; i++) pulse(dcs[i], 256);

        // Minimum-period behaviour: alternate captures at 5, every rise at 9
        pulses(2, 5, 6);
        pulses(3, 9, 4);

        // Stuck high -> timeout with full duty
        note_rise();
        PWM_IN = 1'b1;
        timeout_wait();
        pulse(25, 100);
        check("timeout_held_after_rearm", 32'(TIMEOUT), 1);
        pulses(25, 100, 2);

        // Stuck low -> timeout with zero duty
        timeout_wait();
        pulses(40, 80, 3);

        // Reset three cycles after a capture
        note_rise();
        PWM_IN = 1'b1;
        repeat (2) @(negedge CLK);
        PWM_IN = 1'b0;
        repeat (4) @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("midrst_duty", 32'(DUTY_OUT), 0);
        check("midrst_high", 32'(HIGH_CNT), 0);
        check("midrst_period", 32'(PERIOD_CNT), 0);
        check("midrst_valid", 32'(VALID), 0);
        expq.delete();
        armed    = 0;
        last_cap = -1000;
        last_hi  = 2;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        pulses(25, 100, 3);
        repeat (20) @(negedge CLK);

        check("pending_expected", expq.size(), 0);
        check("overrun_count", ovr_seen, exp_ovr);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
